// File: rtl/mega_mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// mega_mul_seq_pkg
//   Shared definitions for the sequential MEGA/XMEGA multiply unit:
//   operation mode encodings, FSM state type and small mode-decode helpers.
//   No ports (package).
// ---------------------------------------------------------------------------
package mega_mul_seq_pkg;

  // Operation encodings as issued by the execute stage. Bit 2 selects the
  // fractional (FMUL*) variants; bits 1:0 select operand signedness.
  // Encoding 2'b11 in the low bits is reserved and behaves as unsigned.
  localparam logic [2:0] MEGA_MUL_MODE_MUL    = 3'b000;
  localparam logic [2:0] MEGA_MUL_MODE_MULS   = 3'b001;
  localparam logic [2:0] MEGA_MUL_MODE_MULSU  = 3'b010;
  localparam logic [2:0] MEGA_MUL_MODE_FMUL   = 3'b100;
  localparam logic [2:0] MEGA_MUL_MODE_FMULS  = 3'b101;
  localparam logic [2:0] MEGA_MUL_MODE_FMULSU = 3'b110;

  // Position of the fractional flag inside the mode field.
  localparam int MEGA_MUL_FRAC_BIT = 2;

  // Multiply unit controller states.
  typedef enum logic [1:0] {
    MEGA_MUL_ST_IDLE = 2'd0,
    MEGA_MUL_ST_CALC = 2'd1,
    MEGA_MUL_ST_FIX  = 2'd2,
    MEGA_MUL_ST_DONE = 2'd3
  } mega_mul_state_e;

  // Rd is a signed operand for MULS and MULSU (and their fractional forms).
  function automatic logic mode_rd_signed(input logic [1:0] m);
    return (m == MEGA_MUL_MODE_MULS[1:0]) || (m == MEGA_MUL_MODE_MULSU[1:0]);
  endfunction

  // Rr is a signed operand only for MULS/FMULS.
  function automatic logic mode_rr_signed(input logic [1:0] m);
    return (m == MEGA_MUL_MODE_MULS[1:0]);
  endfunction

endpackage

// File: rtl/mega_mul_seq_if.sv
// ---------------------------------------------------------------------------
// mega_mul_seq_if
//   Execute-stage <-> multiply unit bus.
//   Request side : in_valid, in_ready, mode[2:0], rd, rr
//   Response side: out_valid, out_ready, R[2*WIDTH-1:0], flag_c, flag_z
//   Status       : busy
//   master = execute stage (issues operands, consumes result)
//   slave  = multiply unit
// ---------------------------------------------------------------------------
interface mega_mul_seq_if #(
  parameter int WIDTH = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           mode;
  logic [WIDTH-1:0]     rd;
  logic [WIDTH-1:0]     rr;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   R;
  logic                 flag_c;
  logic                 flag_z;
  logic                 busy;

  modport master (
    output in_valid, mode, rd, rr, out_ready,
    input  in_ready, out_valid, R, flag_c, flag_z, busy
  );

  modport slave (
    input  in_valid, mode, rd, rr, out_ready,
    output in_ready, out_valid, R, flag_c, flag_z, busy
  );

endinterface

// File: rtl/mega_mul_seq_step.sv
// ---------------------------------------------------------------------------
// mega_mul_step
//   One iteration of the shift-add multiplier: adds the (already aligned)
//   multiplicand times the current BITS_PER_CYCLE-bit multiplier slice into
//   the accumulator. Purely combinational.
//   i_acc   [2*WIDTH-1:0]     accumulator before this iteration
//   i_mcand [2*WIDTH-1:0]     multiplicand, pre-shifted to this slice's weight
//   i_slice [BITS_PER_CYCLE-1:0] low multiplier bits retired this cycle
//   o_acc   [2*WIDTH-1:0]     accumulator after this iteration
// ---------------------------------------------------------------------------
module mega_mul_step #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        i_acc,
  input  logic [2*WIDTH-1:0]        i_mcand,
  input  logic [BITS_PER_CYCLE-1:0] i_slice,
  output logic [2*WIDTH-1:0]        o_acc
);

  logic [2*WIDTH-1:0] w_sum;

  // Each set bit of the slice contributes the multiplicand at that bit's
  // weight. The sum is taken modulo 2^(2*WIDTH); the true product of two
  // WIDTH-bit magnitudes always fits, so nothing is lost.
  always_comb begin
    w_sum = i_acc;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (i_slice[b]) begin
        w_sum = w_sum + (i_mcand << b);
      end
    end
  end

  assign o_acc = w_sum;

endmodule

// File: rtl/mega_mul_seq.sv
// ---------------------------------------------------------------------------
// mega_mul_seq
//   Iterative multiply unit for MUL/MULS/MULSU/FMUL/FMULS/FMULSU.
//   Operands are converted to sign + magnitude on acceptance, the magnitudes
//   are multiplied by a shift-add loop retiring BITS_PER_CYCLE multiplier
//   bits per cycle, and the sign, fractional shift and flags are applied in
//   a single fix-up cycle.
//   clk    in  core clock, rising edge
//   rst_n  in  asynchronous reset, active low
//   flush  in  synchronous abort of any operation in flight
//   bus    slave side of mega_mul_seq_if (operand handshake, result
//          handshake, R, flag_c, flag_z, busy)
// ---------------------------------------------------------------------------
module mega_mul_seq
  import mega_mul_seq_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  mega_mul_seq_if.slave bus
);

  localparam int N = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mega_mul_state_e        r_state;
  logic                   r_frac;
  logic                   r_neg;
  logic [2*WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]       r_mplier;
  logic [2*WIDTH-1:0]     r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic [2*WIDTH-1:0]     r_result;
  logic                   r_flag_c;
  logic                   r_flag_z;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_rd_neg;
  logic                   w_rr_neg;
  logic [WIDTH-1:0]       w_rd_abs;
  logic [WIDTH-1:0]       w_rr_abs;
  logic [2*WIDTH-1:0]     w_acc_next;
  logic [2*WIDTH-1:0]     w_prod;
  logic [2*WIDTH-1:0]     w_result;

  // in_ready is only ever high in IDLE, so this is the accept condition.
  // flush still wins inside the FSM.
  assign w_accept = r_in_ready && bus.in_valid;

  // Operand conditioning: signed operands are turned into magnitudes and the
  // product sign is remembered separately. Negating the most negative value
  // wraps back to itself, which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    w_rd_neg = mode_rd_signed(bus.mode[1:0]) && bus.rd[WIDTH-1];
    w_rr_neg = mode_rr_signed(bus.mode[1:0]) && bus.rr[WIDTH-1];
    w_rd_abs = w_rd_neg ? -bus.rd : bus.rd;
    w_rr_abs = w_rr_neg ? -bus.rr : bus.rr;
  end

  // Sign fix-up and fractional alignment of the finished magnitude product.
  // The carry flag is taken from the unshifted product, zero from the final
  // (possibly shifted) result.
  always_comb begin
    w_prod   = r_neg ? -r_acc : r_acc;
    w_result = r_frac ? {w_prod[2*WIDTH-2:0], 1'b0} : w_prod;
  end

  mega_mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_slice (r_mplier[BITS_PER_CYCLE-1:0]),
    .o_acc   (w_acc_next)
  );

  // Controller and datapath registers. All handshake outputs are registered
  // here so the execute stage sees clean, glitch-free status. The multiplicand
  // moves left while the multiplier moves right, so the step adder always
  // works on the current slice at its correct weight. R and the flags are
  // only written in FIX; flush and DONE->IDLE leave them holding the last
  // reported result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= MEGA_MUL_ST_IDLE;
      r_frac      <= 1'b0;
      r_neg       <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush) begin
      r_state     <= MEGA_MUL_ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        MEGA_MUL_ST_IDLE: begin
          if (w_accept) begin
            r_frac     <= bus.mode[MEGA_MUL_FRAC_BIT];
            r_neg      <= w_rd_neg ^ w_rr_neg;
            r_mcand    <= {{WIDTH{1'b0}}, w_rd_abs};
            r_mplier   <= w_rr_abs;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= MEGA_MUL_ST_CALC;
          end
        end
        MEGA_MUL_ST_CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          if (r_cnt == CNT_LAST) begin
            r_state <= MEGA_MUL_ST_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        MEGA_MUL_ST_FIX: begin
          r_result    <= w_result;
          r_flag_c    <= w_prod[2*WIDTH-1];
          r_flag_z    <= (w_result == '0);
          r_out_valid <= 1'b1;
          r_state     <= MEGA_MUL_ST_DONE;
        end
        MEGA_MUL_ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= MEGA_MUL_ST_IDLE;
          end
        end
        default: begin
          r_state <= MEGA_MUL_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.R         = r_result;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_z    = r_flag_z;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mega_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mega_mul_seq
//   Scoreboard bench for mega_mul_seq. The main instance (WIDTH=8, one bit
//   per cycle) is driven by directed and random operations whose expected
//   results come from an integer-arithmetic model; a monitor pops and checks
//   them as results appear. Two side instances cover BITS_PER_CYCLE=2 and
//   WIDTH=16.
// ---------------------------------------------------------------------------
module tb_mega_mul_seq;
  import mega_mul_seq_pkg::*;

  typedef struct {
    longint r;
    bit     c;
    bit     z;
    longint acc;
  } expT;

  logic clk;
  logic rst_n;
  logic flush;
  int   bpMode;
  longint cycleCnt;
  int   checkCnt;
  int   passCnt;
  bit   prevValid;
  expT  sbq[$];

  mega_mul_seq_if #(.WIDTH(8))  bus8 ();
  mega_mul_seq_if #(.WIDTH(8))  busB ();
  mega_mul_seq_if #(.WIDTH(16)) busC ();

  mega_mul_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus8)
  );

  mega_mul_seq #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(busB)
  );

  mega_mul_seq #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(busC)
  );

  // Free-running clock and edge counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Consumer backpressure for the main instance: 0 = always ready,
  // 1 = random, 2 = never ready. Changed just after the edge.
  always @(posedge clk) begin
    #1;
    case (bpMode)
      0:       bus8.out_ready = 1'b1;
      1:       bus8.out_ready = ($urandom_range(0, 3) != 0);
      default: bus8.out_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input longint act, input longint req);
    checkCnt++;
    if (act == req) passCnt++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Reference: interpret each operand as a mathematical integer according to
  // the mode, multiply, reduce modulo 2^(2w), then apply the fractional shift.
  function automatic void refModel(input int w, input logic [2:0] m, input longint a,
                                   input longint b, output longint r, output bit c,
                                   output bit z);
    longint sa, sb, p, mask;
    mask = (longint'(1) << (2 * w)) - 1;
    sa = a;
    sb = b;
    if ((m[1:0] == 2'b01 || m[1:0] == 2'b10) && a[w-1]) sa = a - (longint'(1) << w);
    if (m[1:0] == 2'b01 && b[w-1]) sb = b - (longint'(1) << w);
    p = (sa * sb) & mask;
    c = p[2*w-1];
    if (m[2]) p = (p << 1) & mask;
    r = p;
    z = (p == 0);
  endfunction

  // Monitor: every cycle a result is presented it must match the oldest
  // outstanding expectation; the first cycle also checks the latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (bus8.out_valid) begin
        if (sbq.size() == 0) begin
          if (!prevValid) checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          if (!prevValid) checkOutput("latency", cycleCnt - sbq[0].acc, 9);
          checkOutput("R", bus8.R, sbq[0].r);
          checkOutput("flag_c", bus8.flag_c, sbq[0].c);
          checkOutput("flag_z", bus8.flag_z, sbq[0].z);
          if (bus8.out_ready) void'(sbq.pop_front());
        end
      end
      prevValid = bus8.out_valid;
    end
  end

  // Present one operation to the main instance; when tracked, the expected
  // result is queued for the monitor against the accepting edge number.
  task automatic applyStimulus(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                               input bit track, input longint er, input bit ec, input bit ez);
    bit  got;
    expT e;
    @(negedge clk);
    bus8.mode = m;
    bus8.rd = a;
    bus8.rr = b;
    bus8.in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus8.in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("accept", got, 1);
    if (track && got) begin
      e.r = er;
      e.c = ec;
      e.z = ez;
      e.acc = cycleCnt + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  function automatic logic [7:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'hFF;
      3:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic randomOp(input logic [2:0] m);
    logic [7:0] a, b;
    longint er;
    bit ec, ez;
    a = pickOperand();
    b = pickOperand();
    refModel(8, m, longint'(a), longint'(b), er, ec, ez);
    applyStimulus(m, a, b, 1'b1, er, ec, ez);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 2000; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drain", sbq.size(), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, bus8.in_ready, 1);
    checkOutput({tag, "_out_valid"}, bus8.out_valid, 0);
    checkOutput({tag, "_busy"}, bus8.busy, 0);
    checkOutput({tag, "_R"}, bus8.R, 0);
    checkOutput({tag, "_flag_c"}, bus8.flag_c, 0);
    checkOutput({tag, "_flag_z"}, bus8.flag_z, 0);
  endtask

  // Direct single-operation check on a side instance (0: W8/BPC2, 1: W16).
  task automatic runSide(input int which, input logic [2:0] m, input longint a, input longint b);
    int     w, expLat;
    longint er, acc;
    bit     ec, ez, got;
    w = (which == 0) ? 8 : 16;
    expLat = (which == 0) ? 5 : 17;
    refModel(w, m, a, b, er, ec, ez);
    @(negedge clk);
    if (which == 0) begin
      busB.mode = m; busB.rd = a[7:0]; busB.rr = b[7:0]; busB.in_valid = 1'b1;
    end else begin
      busC.mode = m; busC.rd = a[15:0]; busC.rr = b[15:0]; busC.in_valid = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((which == 0) ? busB.in_ready : busC.in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("side_accept", got, 1);
    acc = cycleCnt + 1;
    @(negedge clk);
    busB.in_valid = 1'b0;
    busC.in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((which == 0) ? busB.out_valid : busC.out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("side_out_valid", got, 1);
    checkOutput("side_latency", cycleCnt - acc, expLat);
    if (which == 0) begin
      checkOutput("side_R", busB.R, er);
      checkOutput("side_flag_c", busB.flag_c, ec);
      checkOutput("side_flag_z", busB.flag_z, ez);
    end else begin
      checkOutput("side_R", busC.R, er);
      checkOutput("side_flag_c", busC.flag_c, ec);
      checkOutput("side_flag_z", busC.flag_z, ez);
    end
    @(negedge clk);
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed cases, backpressure, flush, mid-op reset,
  // random operations, then the side instances.
  initial begin
    bit got;
    checkCnt = 0;
    passCnt = 0;
    bpMode = 0;
    prevValid = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus8.in_valid = 1'b0; bus8.mode = '0; bus8.rd = '0; bus8.rr = '0;
    busB.in_valid = 1'b0; busB.mode = '0; busB.rd = '0; busB.rr = '0; busB.out_ready = 1'b1;
    busC.in_valid = 1'b0; busC.mode = '0; busC.rd = '0; busC.rr = '0; busC.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    applyStimulus(MEGA_MUL_MODE_MUL,    8'hFF, 8'hFF, 1, 'hFE01, 1, 0);
    applyStimulus(MEGA_MUL_MODE_MULS,   8'h80, 8'h80, 1, 'h4000, 0, 0);
    applyStimulus(MEGA_MUL_MODE_MULSU,  8'hFF, 8'hFF, 1, 'hFF01, 1, 0);
    applyStimulus(MEGA_MUL_MODE_MUL,    8'h00, 8'h5A, 1, 'h0000, 0, 1);
    applyStimulus(MEGA_MUL_MODE_FMUL,   8'hFF, 8'hFF, 1, 'hFC02, 1, 0);
    applyStimulus(MEGA_MUL_MODE_FMULS,  8'h80, 8'h80, 1, 'h8000, 0, 0);
    applyStimulus(MEGA_MUL_MODE_FMUL,   8'h80, 8'h00, 1, 'h0000, 0, 1);
    applyStimulus(MEGA_MUL_MODE_FMULSU, 8'h80, 8'hFF, 1, 'h0100, 1, 0);
    waitDrain();

    // Backpressure: result held while the consumer stalls, new requests ignored.
    bpMode = 2;
    applyStimulus(MEGA_MUL_MODE_MUL, 8'h0F, 8'h11, 1, 'h00FF, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus8.out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("bp_out_valid_seen", got, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", bus8.in_ready, 0);
      checkOutput("bp_busy", bus8.busy, 1);
      checkOutput("bp_out_valid", bus8.out_valid, 1);
      bus8.in_valid = (i % 2 == 0);
      bus8.rd = 8'($urandom);
      bus8.rr = 8'($urandom);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bpMode = 0;
    waitDrain();
    repeat (12) @(negedge clk);

    // Flush at the third CALC cycle: nothing is reported.
    applyStimulus(MEGA_MUL_MODE_MUL, 8'h55, 8'h33, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", bus8.busy, 0);
    checkOutput("flush_in_ready", bus8.in_ready, 1);
    checkOutput("flush_out_valid", bus8.out_valid, 0);
    repeat (15) @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.rd = 8'h44;
    bus8.rr = 8'h22;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_no_accept", bus8.busy, 0);
    bus8.in_valid = 1'b0;
    flush = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(MEGA_MUL_MODE_MUL, 8'h12, 8'h34, 1, 'h03A8, 0, 0);
    waitDrain();

    // Asynchronous reset in the middle of CALC.
    applyStimulus(MEGA_MUL_MODE_MUL, 8'hAA, 8'hBB, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Random operations in every mode, including the reserved encodings.
    bpMode = 1;
    for (int m = 0; m < 8; m++) begin
      for (int k = 0; k < 150; k++) randomOp(3'(m));
    end
    bpMode = 0;
    waitDrain();

    runSide(0, MEGA_MUL_MODE_MUL, 'hFF, 'hFF);
    runSide(0, MEGA_MUL_MODE_FMULSU, 'h80, 'hFF);
    for (int k = 0; k < 20; k++) runSide(0, 3'($urandom), longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)));
    runSide(1, MEGA_MUL_MODE_MULS, 'h8000, 'h8000);
    for (int k = 0; k < 10; k++) runSide(1, 3'($urandom), longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)));

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
